// File: rtl/alu_operand_sequencer.sv
// Debounced single-button sequencer that captures ALU operand A, operand B and
// the opcode from the switch word, then pulses the flag-register load enable.
module alu_operand_sequencer #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn,
  input  logic [31:0] SW,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [3:0]  op_out,
  output logic        flag_en,
  output logic [1:0]  stage
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_OP   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               sync1_q, sync1_d;
  logic               sync_q, sync_d;
  logic               deb_q, deb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic               flag_pend_q, flag_pend_d;
  logic               flag_q, flag_d;
  logic               press_c;

  // State register for synchronizer, debouncer, FSM and captured operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_A;
      sync1_q     <= 1'b0;
      sync_q      <= 1'b0;
      deb_q       <= 1'b0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      flag_pend_q <= 1'b0;
      flag_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync_q      <= sync_d;
      deb_q       <= deb_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      flag_pend_q <= flag_pend_d;
      flag_q      <= flag_d;
    end
  end

  // Next-state: debounce, press detection and per-state capture
  always_comb begin
    state_d     = state_q;
    sync1_d     = btn;
    sync_d      = sync1_q;
    deb_d       = deb_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    flag_pend_d = 1'b0;
    flag_d      = flag_pend_q;
    press_c     = 1'b0;

    if (sync_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_d   = sync_q;
      cnt_d   = '0;
      // Only the rising debounced transition is a press
      press_c = sync_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (press_c) begin
      unique case (state_q)
        S_A: begin
          a_d     = SW;
          state_d = S_B;
        end
        S_B: begin
          b_d     = SW;
          state_d = S_OP;
        end
        S_OP: begin
          op_d        = SW[3:0];
          flag_pend_d = 1'b1;
          state_d     = S_DONE;
        end
        S_DONE: begin
          state_d = S_A;
        end
        default: state_d = S_A;
      endcase
    end
  end

  assign a_out   = a_q;
  assign b_out   = b_q;
  assign op_out  = op_q;
  assign flag_en = flag_q;
  assign stage   = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with DEB_CYCLES=4: press table plus
// hand-written reset, bounce, latency, hold and mid-operation reset sequences.
module tb_alu_operand_sequencer;

  localparam int unsigned DEB = 4;

  logic        clk;
  logic        rst_n;
  logic        btn;
  logic [31:0] SW;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic [3:0]  op_out;
  logic        flag_en;
  logic [1:0]  stage;

  int n_vec;
  int n_miss;

  typedef struct {
    logic [31:0] sw;
    logic [1:0]  stage;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        flag;
  } vec_t;

  vec_t vecs[4];

  alu_operand_sequencer #(.DEB_CYCLES(DEB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn     (btn),
    .SW      (SW),
    .a_out   (a_out),
    .b_out   (b_out),
    .op_out  (op_out),
    .flag_en (flag_en),
    .stage   (stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [1:0] st, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op, input logic fl);
    chk({name, ".stage"}, 32'(stage), 32'(st));
    chk({name, ".a"}, a_out, a);
    chk({name, ".b"}, b_out, b);
    chk({name, ".op"}, 32'(op_out), 32'(op));
    chk({name, ".flag"}, 32'(flag_en), 32'(fl));
  endtask

  task automatic release_btn();
    btn = 1'b0;
    repeat (DEB + 2) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int flag_seen;
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    btn    = 1'b0;
    SW     = '0;

    vecs[0] = '{sw: 32'h0000_0005, stage: 2'd1, a: 32'h5, b: 32'h0, op: 4'h0, flag: 1'b0};
    vecs[1] = '{sw: 32'h0000_0003, stage: 2'd2, a: 32'h5, b: 32'h3, op: 4'h0, flag: 1'b0};
    vecs[2] = '{sw: 32'h0000_0002, stage: 2'd3, a: 32'h5, b: 32'h3, op: 4'h2, flag: 1'b1};
    vecs[3] = '{sw: 32'h1234_5678, stage: 2'd0, a: 32'h5, b: 32'h3, op: 4'h2, flag: 1'b0};

    // Reset with button held and switches all ones
    btn = 1'b1;
    SW  = 32'hFFFF_FFFF;
    repeat (3) tick();
    chk_all("rst", 2'd0, 32'h0, 32'h0, 4'h0, 1'b0);
    rst_n = 1'b1;
    repeat (DEB + 1) tick();
    chk("rst_hold.pre_stage", 32'(stage), 32'd0);
    tick();
    chk("rst_hold.stage", 32'(stage), 32'd1);
    chk("rst_hold.a", a_out, 32'hFFFF_FFFF);
    repeat (20) tick();
    chk("rst_hold.once", 32'(stage), 32'd1);
    release_btn();

    // Full sequence from the table
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] prev_stage;
      prev_stage = stage;
      SW  = vecs[i].sw;
      btn = 1'b1;
      repeat (DEB + 1) tick();
      chk($sformatf("seq%0d.pre", i), 32'(stage), 32'(prev_stage));
      tick();
      chk_all($sformatf("seq%0d.cap", i), vecs[i].stage, vecs[i].a, vecs[i].b, vecs[i].op, 1'b0);
      tick();
      chk($sformatf("seq%0d.flag1", i), 32'(flag_en), 32'(vecs[i].flag));
      tick();
      chk($sformatf("seq%0d.flag2", i), 32'(flag_en), 32'd0);
      release_btn();
    end

    // Bounce rejection in S_A
    do_reset();
    SW = 32'hCAFE_0001;
    for (int w = 1; w <= 3; w++) begin
      btn = 1'b1;
      repeat (w) tick();
      btn = 1'b0;
      repeat (2) tick();
    end
    repeat (4) tick();
    chk("bounce.stage", 32'(stage), 32'd0);
    chk("bounce.a", a_out, 32'h0);
    btn = 1'b1;
    repeat (DEB + 1) tick();
    chk("bounce.pre", 32'(stage), 32'd0);
    tick();
    chk("bounce.stage_cap", 32'(stage), 32'd1);
    chk("bounce.a_cap", a_out, 32'hCAFE_0001);
    repeat (4) tick();
    release_btn();
    chk("bounce.after", 32'(stage), 32'd1);

    // Latency and hold in S_B: SW changed after capture edge is ignored
    SW  = 32'hDEAD_BEEF;
    btn = 1'b1;
    repeat (DEB + 1) tick();
    chk("lat.pre_b", b_out, 32'h0);
    tick();
    chk("lat.b", b_out, 32'hDEAD_BEEF);
    chk("lat.stage", 32'(stage), 32'd2);
    SW = 32'h0BAD_F00D;
    flag_seen = 0;
    repeat (94) begin
      tick();
      if (flag_en) flag_seen++;
    end
    chk("hold.stage", 32'(stage), 32'd2);
    chk("hold.b", b_out, 32'hDEAD_BEEF);
    chk("hold.noflag", 32'(flag_seen), 32'd0);
    release_btn();
    chk("hold.rel", 32'(stage), 32'd2);

    // Opcode takes only SW[3:0]; reset during the flag cycle
    SW  = 32'h9876_543C;
    btn = 1'b1;
    repeat (DEB + 2) tick();
    chk("op.val", 32'(op_out), 32'hC);
    tick();
    chk("op.flag", 32'(flag_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all("rst_flag", 2'd0, 32'h0, 32'h0, 4'h0, 1'b0);
    btn = 1'b0;
    tick();
    rst_n = 1'b1;
    flag_seen = 0;
    repeat (20) begin
      tick();
      if (flag_en) flag_seen++;
    end
    chk("rst_flag.noflag", 32'(flag_seen), 32'd0);
    chk("rst_flag.stage", 32'(stage), 32'd0);

    // Reset mid-debounce at cnt=2
    SW  = 32'h1111_2222;
    btn = 1'b1;
    repeat (4) tick();
    chk("rst_cnt.cnt", 32'(dut.cnt_q), 32'd2);
    rst_n = 1'b0;
    btn   = 1'b0;
    #1;
    chk_all("rst_cnt", 2'd0, 32'h0, 32'h0, 4'h0, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (15) tick();
    chk("rst_cnt.stage", 32'(stage), 32'd0);
    chk("rst_cnt.a", a_out, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
